// File: rtl/hash_bridge_pkg.sv
// rtl/hash_bridge_pkg.sv - register map, status/ctrl bit positions and byte-swap helper
package hash_bridge_pkg;

  // Avalon word addresses
  localparam logic [5:0] ADDR_DATA_LO     = 6'h00;
  localparam logic [5:0] ADDR_DATA_HI     = 6'h01;
  localparam logic [5:0] ADDR_DATA_LO_SW  = 6'h02;
  localparam logic [5:0] ADDR_DATA_HI_SW  = 6'h03;
  localparam logic [5:0] ADDR_STATUS      = 6'h04;
  localparam logic [5:0] ADDR_CTRL        = 6'h05;
  localparam logic [5:0] ADDR_SRST        = 6'h0F;
  localparam logic [5:0] ADDR_DIGEST_BASE = 6'h20;

  // STATUS register bit positions
  localparam int ST_HASH_READY = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_EMPTY      = 2;
  localparam int ST_BUSY       = 3;
  localparam int ST_IRQ_PEND   = 4;
  localparam int ST_LEVEL_LSB  = 8;

  // CTRL register bit positions
  localparam int CTRL_SRST    = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_IRQ_CLR = 2;

  // Reverse the byte order of a 32-bit bus word
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/hash_avalon_bridge_if.sv
// rtl/hash_avalon_bridge_if.sv - Avalon-MM slave bus bundle for the hash bridge
interface hash_avalon_bridge_if;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        write;
  logic        read;
  logic        chipselect;
  logic [31:0] readdata;
  logic        waitrequest;

  modport slave (
    input  address, writedata, byteenable, write, read, chipselect,
    output readdata, waitrequest
  );

  modport master (
    output address, writedata, byteenable, write, read, chipselect,
    input  readdata, waitrequest
  );
endinterface

// File: rtl/hash_bridge_fifo.sv
// rtl/hash_bridge_fifo.sv - show-ahead input FIFO feeding the hash core
module hash_bridge_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [DW-1:0]      push_data,
  input  logic               pop,
  output logic [DW-1:0]      head,
  output logic               full,
  output logic               empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next-state for storage, pointers and occupancy; flush overrides traffic
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/hash_avalon_bridge.sv
// rtl/hash_avalon_bridge.sv - Avalon-MM slave bridging a CPU to a streaming hash core
module hash_avalon_bridge
  import hash_bridge_pkg::*;
#(
  parameter int HS         = 512,
  parameter int DW         = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int SWAP_OUT   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hash_avalon_bridge_if.slave   avs,
  output logic                  irq,
  output logic                  core_rst,
  output logic                  core_src_ready,
  input  logic                  core_src_read,
  output logic [DW-1:0]         core_din,
  output logic                  core_dst_ready,
  input  logic                  core_dst_write,
  input  logic [DW-1:0]         core_dout
);

  localparam int NWORDS = HS / DW;
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NWORDS - 1);

  logic [31:0]   lo_q, lo_d;
  logic [31:0]   hi_q, hi_d;
  logic [HS-1:0] digest_q, digest_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          hash_ready_q, hash_ready_d;
  logic          busy_q, busy_d;
  logic          irq_pend_q, irq_pend_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic          core_rst_q, core_rst_d;
  logic [31:0]   readdata_q, readdata_d;

  logic          wr_en, rd_en;
  logic [31:0]   wd_sw;
  logic          push_req, push;
  logic [DW-1:0] push_word;
  logic          srst, irq_clr, data_wr;
  logic          fifo_full, fifo_empty, pop;
  logic [LW-1:0] fifo_level;
  logic [DW-1:0] dout_sw, cap_word;
  logic          complete;
  logic [31:0]   status_word, digest_word;
  logic          unused_be;

  assign wr_en     = avs.chipselect & avs.write;
  assign rd_en     = avs.chipselect & avs.read;
  assign wd_sw     = bswap32(avs.writedata);
  assign unused_be = ^avs.byteenable;

  // Which writes push a core word: the HI half completes a 64-bit word, a 32-bit core takes LO directly
  if (DW == 64) begin : g_push64
    always_comb begin
      push_req  = 1'b0;
      push_word = {avs.writedata, lo_q};
      if (wr_en && avs.address == ADDR_DATA_HI) begin
        push_req  = 1'b1;
        push_word = {avs.writedata, lo_q};
      end else if (wr_en && avs.address == ADDR_DATA_HI_SW) begin
        push_req  = 1'b1;
        push_word = {wd_sw, lo_q};
      end
    end
  end else begin : g_push32
    always_comb begin
      push_req  = 1'b0;
      push_word = avs.writedata;
      if (wr_en && avs.address == ADDR_DATA_LO) begin
        push_req  = 1'b1;
        push_word = avs.writedata;
      end else if (wr_en && avs.address == ADDR_DATA_LO_SW) begin
        push_req  = 1'b1;
        push_word = wd_sw;
      end
    end
  end

  // A pop on a full FIFO frees space only after the edge, so the stalled push waits one more cycle
  assign avs.waitrequest = push_req & fifo_full;
  assign push            = push_req & ~fifo_full;

  assign srst    = wr_en & ((avs.address == ADDR_CTRL && avs.writedata[CTRL_SRST]) ||
                            avs.address == ADDR_SRST);
  assign irq_clr = wr_en & (avs.address == ADDR_CTRL) & avs.writedata[CTRL_IRQ_CLR];
  assign data_wr = wr_en & (avs.address[5:2] == 4'b0000);
  assign pop     = core_src_read & ~fifo_empty;

  hash_bridge_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush     (srst),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (core_din),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  for (genvar b = 0; b < DW / 8; b++) begin : g_swap
    assign dout_sw[8*b +: 8] = core_dout[DW-8-8*b +: 8];
  end
  assign cap_word = (SWAP_OUT != 0) ? dout_sw : core_dout;
  assign complete = core_dst_write & (out_cnt_q == LAST_CNT);

  assign core_src_ready = fifo_empty;
  assign core_dst_ready = 1'b0;
  assign core_rst       = core_rst_q;
  assign irq            = irq_q;
  assign avs.readdata   = readdata_q;

  // Staging registers for the two halves of a bus-written word
  always_comb begin
    lo_d = lo_q;
    hi_d = hi_q;
    if (wr_en) begin
      case (avs.address)
        ADDR_DATA_LO:    lo_d = avs.writedata;
        ADDR_DATA_LO_SW: lo_d = wd_sw;
        ADDR_DATA_HI:    if (DW == 64) hi_d = avs.writedata;
        ADDR_DATA_HI_SW: if (DW == 64) hi_d = wd_sw;
        default: ;
      endcase
    end
  end

  // Digest capture, completion counting and status flags; soft reset dominates
  always_comb begin
    digest_d     = digest_q;
    out_cnt_d    = out_cnt_q;
    hash_ready_d = hash_ready_q;
    busy_d       = busy_q;
    irq_pend_d   = irq_pend_q;
    irq_en_d     = irq_en_q;
    if (wr_en && avs.address == ADDR_CTRL) irq_en_d = avs.writedata[CTRL_IRQ_EN];
    if (srst) begin
      digest_d     = '0;
      out_cnt_d    = '0;
      hash_ready_d = 1'b0;
      busy_d       = 1'b0;
      irq_pend_d   = 1'b0;
    end else begin
      if (core_dst_write) begin
        digest_d  = {cap_word, digest_q[HS-1:DW]};
        out_cnt_d = complete ? '0 : out_cnt_q + CW'(1);
      end
      if (data_wr)  hash_ready_d = 1'b0;
      if (complete) hash_ready_d = 1'b1;
      if (complete) busy_d = 1'b0;
      if (push)     busy_d = 1'b1;
      if (complete) irq_pend_d = 1'b1;
      if (irq_clr)  irq_pend_d = 1'b0;
    end
    core_rst_d = srst;
    irq_d      = irq_pend_q & irq_en_q;
  end

  // Digest word selected by the low address bits; indices past the digest read as zero
  always_comb begin
    digest_word = '0;
    for (int i = 0; i < HS / 32; i++) begin
      if (avs.address[4:0] == 5'(i)) digest_word = digest_q[32*i +: 32];
    end
  end

  // Status word assembly and registered read mux, updated only on a selected read
  always_comb begin
    status_word                  = '0;
    status_word[ST_HASH_READY]   = hash_ready_q;
    status_word[ST_FULL]         = fifo_full;
    status_word[ST_EMPTY]        = fifo_empty;
    status_word[ST_BUSY]         = busy_q;
    status_word[ST_IRQ_PEND]     = irq_pend_q;
    status_word[ST_LEVEL_LSB+:8] = 8'(fifo_level);
    readdata_d = readdata_q;
    if (rd_en) begin
      case (avs.address)
        ADDR_DATA_LO: readdata_d = lo_q;
        ADDR_DATA_HI: readdata_d = hi_q;
        ADDR_STATUS:  readdata_d = status_word;
        ADDR_CTRL:    readdata_d = {30'b0, irq_en_q, 1'b0};
        default:      readdata_d = ((avs.address & ADDR_DIGEST_BASE) != '0) ? digest_word : 32'h0;
      endcase
    end
  end

  // Bridge state registers; core held in reset while reset_n is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_q         <= '0;
      hi_q         <= '0;
      digest_q     <= '0;
      out_cnt_q    <= '0;
      hash_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      irq_pend_q   <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      core_rst_q   <= 1'b1;
      readdata_q   <= '0;
    end else begin
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      digest_q     <= digest_d;
      out_cnt_q    <= out_cnt_d;
      hash_ready_q <= hash_ready_d;
      busy_q       <= busy_d;
      irq_pend_q   <= irq_pend_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      core_rst_q   <= core_rst_d;
      readdata_q   <= readdata_d;
    end
  end

endmodule

// File: tb/tb_hash_avalon_bridge.sv
// tb/tb_hash_avalon_bridge.sv - randomized self-checking bench for hash_avalon_bridge
module tb_hash_avalon_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        irq, core_rst, core_src_ready, core_src_read;
  logic        core_dst_ready, core_dst_write;
  logic [63:0] core_din, core_dout;

  always #5 clk = ~clk;

  hash_avalon_bridge_if bus ();

  hash_avalon_bridge #(
    .HS         (512),
    .DW         (64),
    .FIFO_DEPTH (8),
    .SWAP_OUT   (1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs            (bus),
    .irq            (irq),
    .core_rst       (core_rst),
    .core_src_ready (core_src_ready),
    .core_src_read  (core_src_read),
    .core_din       (core_din),
    .core_dst_ready (core_dst_ready),
    .core_dst_write (core_dst_write),
    .core_dout      (core_dout)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [63:0] m_fifo[$];
  logic [63:0] m_hist[$];
  int          m_cnt;
  bit          m_hr, m_busy, m_pend, m_en;
  logic [31:0] m_lo, m_hi;

  function automatic logic [31:0] sw32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] sw64(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(7-i) +: 8];
    return r;
  endfunction

  // digest = last 8 captured words, newest in the most significant position
  function automatic logic [31:0] m_digest32(input int i);
    logic [63:0] w;
    if (i >= 16) return 32'h0;
    w = m_hist[m_hist.size() - 8 + i / 2];
    return (i % 2) ? w[63:32] : w[31:0];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0]    = m_hr;
    s[1]    = (m_fifo.size() == 8);
    s[2]    = (m_fifo.size() == 0);
    s[3]    = m_busy;
    s[4]    = m_pend;
    s[15:8] = 8'(m_fifo.size());
    return s;
  endfunction

  task automatic m_soft_reset();
    m_fifo.delete();
    m_hist.delete();
    repeat (8) m_hist.push_back(64'h0);
    m_cnt  = 0;
    m_hr   = 0;
    m_busy = 0;
    m_pend = 0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.write = 1'b1; bus.chipselect = 1'b1;
    n = 0;
    while (bus.waitrequest && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("wr_timeout", {63'b0, bus.waitrequest}, 64'h0);
    @(posedge clk);
    #1;
    bus.write = 1'b0; bus.chipselect = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.read = 1'b1; bus.chipselect = 1'b1;
    @(posedge clk);
    #1;
    bus.read = 1'b0; bus.chipselect = 1'b0;
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic push64(input logic [31:0] lo, input logic [31:0] hi, input bit swap);
    wr(swap ? 6'h02 : 6'h00, lo);
    wr(swap ? 6'h03 : 6'h01, hi);
    m_lo = swap ? sw32(lo) : lo;
    m_hi = swap ? sw32(hi) : hi;
    m_fifo.push_back({m_hi, m_lo});
    m_busy = 1;
    m_hr   = 0;
  endtask

  task automatic pop_core();
    @(negedge clk);
    if (m_fifo.size() > 0) check("core_din_head", core_din, m_fifo[0]);
    core_src_read = 1'b1;
    @(posedge clk);
    #1;
    core_src_read = 1'b0;
    if (m_fifo.size() > 0) void'(m_fifo.pop_front());
  endtask

  task automatic capture(input logic [63:0] w);
    @(negedge clk);
    core_dout = w; core_dst_write = 1'b1;
    @(posedge clk);
    #1;
    core_dst_write = 1'b0;
    m_hist.push_back(sw64(w));
    m_cnt++;
    if (m_cnt == 8) begin
      m_cnt  = 0;
      m_hr   = 1;
      m_pend = 1;
      m_busy = 0;
    end
  endtask

  task automatic check_status(input string tag);
    logic [31:0] s;
    rd(6'h04, s);
    check(tag, s, m_status());
    check({tag, "_irq"}, irq, m_pend & m_en);
  endtask

  task automatic ctrl_write(input logic [31:0] d);
    wr(6'h05, d);
    m_en = d[1];
    if (d[0]) m_soft_reset();
    else if (d[2]) m_pend = 0;
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  a;
    logic [31:0] lo9, hi9;
    int          op;

    reset_n = 1'b0;
    bus.address = '0; bus.writedata = '0; bus.byteenable = 4'hF;
    bus.write = 1'b0; bus.read = 1'b0; bus.chipselect = 1'b0;
    core_src_read = 1'b0; core_dst_write = 1'b0; core_dout = '0;
    m_en = 0; m_lo = '0; m_hi = '0;
    m_soft_reset();

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_core_rst", core_rst, 1);
    check("rst_src_ready", core_src_ready, 1);
    check("rst_irq", irq, 0);
    check("rst_waitrequest", bus.waitrequest, 0);
    check("rst_readdata", bus.readdata, 0);
    check("rst_dst_ready", core_dst_ready, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_core_rst", core_rst, 0);
    rd(6'h04, r);
    check("rel_status", r, 32'h0000_0004);

    // native and swapped pushes
    push64(32'h03020100, 32'h07060504, 0);
    check("push_native_din", core_din, 64'h0706050403020100);
    check("push_native_ready", core_src_ready, 0);
    pop_core();
    push64(32'h03020100, 32'h07060504, 1);
    check("push_swap_din", core_din, 64'h0405060700010203);
    pop_core();
    check_status("after_pops");

    // fill to full, stalled push released by a single pop
    ctrl_write(32'h1);
    for (int i = 0; i < 8; i++) push64($urandom, $urandom, 1'($urandom_range(0, 1)));
    check_status("full8");
    lo9 = $urandom; hi9 = $urandom;
    wr(6'h00, lo9);
    m_lo = lo9;
    @(negedge clk);
    bus.address = 6'h01; bus.writedata = hi9; bus.write = 1'b1; bus.chipselect = 1'b1;
    #1;
    check("wait_full_a", bus.waitrequest, 1);
    @(negedge clk);
    check("wait_full_b", bus.waitrequest, 1);
    check("wait_head", core_din, m_fifo[0]);
    core_src_read = 1'b1;
    @(posedge clk);
    #1;
    core_src_read = 1'b0;
    void'(m_fifo.pop_front());
    @(negedge clk);
    check("wait_released", bus.waitrequest, 0);
    @(posedge clk);
    #1;
    bus.write = 1'b0; bus.chipselect = 1'b0;
    m_hi = hi9;
    m_fifo.push_back({hi9, lo9});
    m_hr = 0;
    check_status("refull8");

    // digest capture, completion and interrupt
    ctrl_write(32'h1);
    ctrl_write(32'h2);
    for (int i = 0; i < 8; i++) capture(64'h0011223344556677);
    check("irq_lag", irq, 0);
    @(posedge clk);
    #1;
    check("irq_set", irq, 1);
    check_status("hash_done");
    rd(6'h20, r);
    check("digest_w0", r, 32'h33221100);
    rd(6'h21, r);
    check("digest_w1", r, 32'h77665544);
    ctrl_write(32'h6);
    @(posedge clk);
    #1;
    check("irq_cleared", irq, 0);
    wr(6'h00, 32'h12345678);
    m_lo = 32'h12345678;
    m_hr = 0;
    check_status("hr_cleared");

    // soft reset via legacy alias keeps irq_en
    for (int i = 0; i < 3; i++) push64($urandom, $urandom, 0);
    wr(6'h0F, 32'h0);
    m_soft_reset();
    check("srst_pulse", core_rst, 1);
    @(posedge clk);
    #1;
    check("srst_end", core_rst, 0);
    rd(6'h04, r);
    check("srst_status", r, 32'h0000_0004);
    rd(6'h05, r);
    check("srst_irq_en", r, 32'h2);

    // randomized traffic against the model
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2: begin
          if (m_fifo.size() < 8) push64($urandom, $urandom, 1'($urandom_range(0, 1)));
          else pop_core();
        end
        3, 4: pop_core();
        5, 6: capture({$urandom, $urandom});
        7: check_status("rnd_status");
        8: begin
          case ($urandom_range(0, 4))
            0: begin rd(6'h00, r); check("rnd_lo", r, m_lo); end
            1: begin rd(6'h01, r); check("rnd_hi", r, m_hi); end
            2: begin rd(6'h05, r); check("rnd_ctrl", r, {30'b0, m_en, 1'b0}); end
            3: begin
              a = 6'h10 + 6'($urandom_range(0, 15));
              rd(a, r);
              check("rnd_unmapped", r, 32'h0);
            end
            default: begin
              a = 6'h20 + 6'($urandom_range(0, 31));
              rd(a, r);
              check("rnd_digest", r, m_digest32(int'(a) - 32));
            end
          endcase
        end
        default: begin
          r = '0;
          r[0] = ($urandom_range(0, 7) == 0);
          r[1] = 1'($urandom_range(0, 1));
          r[2] = 1'($urandom_range(0, 1));
          ctrl_write(r);
        end
      endcase
    end
    check_status("final_status");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
